onchip_mem_arbiter: RTL and testbench
=====================================

// Module: onchip_mem_arbiter
// PURPOSE
// - Shares one single-port on-chip RAM (4096 x 32, byte enables, unregistered q, 1-cycle read) between two Avalon-MM masters.
// - Round-robin arbitration with bounded ownership:
//   - the owner keeps the port for up to HOLD_MAX back-to-back transfers;
//   - after that the port is forced over if the other master waits.
// - Sits between the interconnect and the RAM instance. Drives the RAM clock enable, chip select, write, byte enable and address.
// PARAMETERS
// - ADDR_W    12  word address width (4096 words)
// - DATA_W    32  data width; BE_W = DATA_W/8
// - HOLD_MAX  4   max consecutive accepted transfers per owner while other master requests (1..15)
// PORTS
// - clk               in   1       single clock, all logic rising-edge
// - reset             in   1       synchronous, active-high
// - mN_address        in   ADDR_W  master N word address (N = 0,1)
// - mN_byteenable     in   BE_W    master N byte lanes for writes
// - mN_read           in   1       master N read request
// - mN_write          in   1       master N write request
// - mN_writedata      in   DATA_W  master N write data
// - mN_waitrequest    out  1       master N stall; request accepted in a cycle where req & ~waitrequest
// - mN_readdata       out  DATA_W  master N read data
// - mN_readdatavalid  out  1       master N read data valid, 1 cycle after acceptance
// - mem_address       out  ADDR_W  RAM address
// - mem_byteenable    out  BE_W    RAM byte enables (all ones on reads)
// - mem_chipselect    out  1       RAM select, high only for an accepted transfer
// - mem_write         out  1       RAM write
// - mem_writedata     out  DATA_W  RAM write data
// - mem_clken         out  1       RAM clock enable, held high except during reset
// - mem_readdata      in   DATA_W  RAM q (valid cycle after address)
// BEHAVIOUR
// - reqN = mN_read | mN_write. If both read and write are set, the request is a write and the read is ignored.
// - FSM states:
//   - IDLE: no owner.
//   - OWN0 / OWN1: owner of the port.
// - Grant is combinational from state, req0, req1, hold_cnt and last:
//   - IDLE, one requester: that master is granted.
//   - IDLE, both requesting: grant the master != last (last resets to 1, so m0 wins first).
//   - OWNn, reqn=1, hold_cnt<HOLD_MAX: keep n.
//   - OWNn, reqn=1, hold_cnt=HOLD_MAX, other requests: grant other.
//   - OWNn, reqn=1, hold_cnt=HOLD_MAX, other idle: keep n and saturate hold_cnt.
//   - OWNn, reqn=0: grant other if requesting, else go IDLE.
// - Accept and counter updates:
//   - At most one transfer is accepted per cycle.
//   - mN_waitrequest = reqN & ~grantN; it is 1 while reset is high.
//   - On accept: state <= OWNgrant, last <= grant.
//   - hold_cnt <= (grant == previous owner) ? hold_cnt+1 : 1.
// - Memory mux:
//   - mem_* carry the granted master's fields.
//   - mem_chipselect = accept; mem_write = accept & granted write.
//   - mem_byteenable = write ? mN_byteenable : all ones.
// - Read return:
//   - On read accept, register rd_pend <= 1 and rd_sel <= grant.
//   - Next cycle, mN_readdatavalid = rd_pend & (rd_sel == N).
//   - mN_readdata = mem_readdata, unmasked to both masters.
// - Pipelining: a read may be accepted every cycle. Read followed by write, or write followed by read, is legal back-to-back. No bubbles.
// - Reset values: state=IDLE, last=1, hold_cnt=0, rd_pend=0, both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
// - Reset mid-read: rd_pend is cleared, so the read accepted in the cycle before reset returns no readdatavalid. Masters must reissue.
// - hold_cnt width is 4 bits and saturates at HOLD_MAX, never wrapping.
// STRUCTURE
// - Package onchip_mem_arb_pkg: state enum {IDLE, OWN0, OWN1}, HOLD_W=4, master index type.
// - Sub-module rr_hold_arb2: the 2-way round-robin grant with hold counter and last pointer. Outputs grant0, grant1, accept.
// - The top level holds the memory mux and the read-return pipeline register.
// TESTING
// - Reset held 3 cycles with m0_read=1:
//   - waitrequest0=1, mem_chipselect=0, no readdatavalid;
//   - the first cycle after reset deasserts accepts m0.
// - m0 writes 0xDEADBEEF to addr 0x010 with be=4'b0011, then reads it:
//   - m0_readdatavalid is high exactly 1 cycle after the read accept;
//   - the low 16 bits of m0_readdata are 0xBEEF.
// - req0 and req1 both held continuously, HOLD_MAX=4:
//   - grant pattern is m0 x4, m1 x4, m0 x4;
//   - readdatavalid is routed to the correct master each cycle.
// - Only m1 requesting, 10 back-to-back reads:
//   - 10 accepts with zero waitrequest;
//   - hold_cnt saturates at 4 and m1 keeps the port.
// - m0 issues read and write together at addr 0x020 with data 0x12345678:
//   - the RAM is written;
//   - no readdatavalid is produced.
// - m0 read accepted at cycle T, reset asserted at T+1:
//   - no m0_readdatavalid at T+1;
//   - state is IDLE afterwards.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter: FSM states, hold counter
// width, master index and the hold-counter update rule.
package onchip_mem_arb_pkg;

  localparam int unsigned HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic mst_idx_t;

  // Consecutive-ownership count: restarts at 1 on an owner change, saturates at lim.
  function automatic logic [HOLD_W-1:0] hold_next(input logic              same_owner,
                                                  input logic [HOLD_W-1:0] cnt,
                                                  input logic [HOLD_W-1:0] lim);
    logic [HOLD_W-1:0] nxt;
    nxt = HOLD_W'(1);
    if (same_owner) begin
      nxt = (cnt >= lim) ? lim : cnt + HOLD_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle for the arbiter: both Avalon-MM master ports plus the RAM port.
interface onchip_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  // Arbiter side
  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  // Interconnect / RAM side
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/rr_hold_arb2.sv
// Two-way round-robin arbiter with bounded ownership: the owner keeps the port
// for up to HOLD_MAX consecutive transfers while the other master waits.
module rr_hold_arb2
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1,
  output logic accept
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  arb_state_e        state_q, state_d;
  mst_idx_t          last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic     gvalid;
  mst_idx_t gsel;
  mst_idx_t own_sel;
  logic     own_req;
  logic     oth_req;
  logic     same_owner;

  always_comb begin
    gvalid     = 1'b0;
    gsel       = 1'b0;
    state_d    = IDLE;
    last_d     = last_q;
    hold_cnt_d = '0;

    own_sel = (state_q == OWN1);
    own_req = own_sel ? req1 : req0;
    oth_req = own_sel ? req0 : req1;

    if (state_q == IDLE) begin
      gvalid = req0 | req1;
      gsel   = (req0 && req1) ? ~last_q : req1;
    end else if (own_req && !(oth_req && (hold_cnt_q >= HOLD_LIM))) begin
      gvalid = 1'b1;
      gsel   = own_sel;
    end else if (oth_req) begin
      gvalid = 1'b1;
      gsel   = ~own_sel;
    end

    grant0 = gvalid & ~gsel & ~reset;
    grant1 = gvalid &  gsel & ~reset;
    accept = grant0 | grant1;

    same_owner = (state_q != IDLE) && (gsel == own_sel);

    // Any cycle without an accepted transfer releases ownership.
    if (accept) begin
      state_d    = gsel ? OWN1 : OWN0;
      last_d     = gsel;
      hold_cnt_d = hold_next(same_owner, hold_cnt_q, HOLD_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters: memory
// mux, per-master stall, and the one-cycle read return routing.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_MAX = 4
) (
  input logic                 clk,
  input logic                 reset,
  onchip_mem_arbiter_if.slave bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic     req0, req1;
  logic     grant0, grant1, accept;
  mst_idx_t sel;
  logic     sel_write;

  logic     rd_pend_q, rd_pend_d;
  mst_idx_t rd_sel_q, rd_sel_d;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  rr_hold_arb2 #(
    .HOLD_MAX(HOLD_MAX)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .grant0(grant0),
    .grant1(grant1),
    .accept(accept)
  );

  always_comb begin
    sel       = grant1;
    // Write wins when a master raises read and write together.
    sel_write = sel ? bus.m1_write : bus.m0_write;

    bus.mem_address    = sel ? bus.m1_address   : bus.m0_address;
    bus.mem_writedata  = sel ? bus.m1_writedata : bus.m0_writedata;
    bus.mem_byteenable = sel_write ? (sel ? bus.m1_byteenable : bus.m0_byteenable)
                                   : {BE_W{1'b1}};
    bus.mem_chipselect = accept;
    bus.mem_write      = accept & sel_write;
    bus.mem_clken      = ~reset;

    bus.m0_waitrequest = reset | (req0 & ~grant0);
    bus.m1_waitrequest = reset | (req1 & ~grant1);

    bus.m0_readdata      = bus.mem_readdata;
    bus.m1_readdata      = bus.mem_readdata;
    bus.m0_readdatavalid = rd_pend_q & ~rd_sel_q & ~reset;
    bus.m1_readdatavalid = rd_pend_q &  rd_sel_q & ~reset;

    rd_pend_d = accept & ~sel_write;
    rd_sel_d  = sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter with a behavioural RAM model.
module tb_onchip_mem_arbiter;
  import onchip_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  onchip_mem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  onchip_mem_arbiter #(
    .ADDR_W  (12),
    .DATA_W  (32),
    .HOLD_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled write, q registered from the selected address.
  logic [31:0] ram [4096];
  logic [31:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_address];
      end
    end
  end
  assign bus.mem_readdata = ram_q;

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  logic [31:0] ref_mem [4096];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pop due read returns, then check the RAM port and push new reads.
  logic        mon_req0, mon_req1, mon_acc0, mon_acc1, mon_g, mon_wr;
  logic [11:0] mon_addr;
  logic [3:0]  mon_be;
  logic [31:0] mon_wd;
  rd_exp_t     mon_e;
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      check_eq("rst_rdv0", bus.m0_readdatavalid, 0);
      check_eq("rst_rdv1", bus.m1_readdatavalid, 0);
      check_eq("rst_cs", bus.mem_chipselect, 0);
      check_eq("rst_memwr", bus.mem_write, 0);
      check_eq("rst_clken", bus.mem_clken, 0);
    end else begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("rdv0", bus.m0_readdatavalid, !mon_e.sel);
        check_eq("rdv1", bus.m1_readdatavalid, mon_e.sel);
        check_eq("rdata", mon_e.sel ? bus.m1_readdata : bus.m0_readdata, mon_e.data);
      end else begin
        check_eq("rdv0_idle", bus.m0_readdatavalid, 0);
        check_eq("rdv1_idle", bus.m1_readdatavalid, 0);
      end
      mon_req0 = bus.m0_read | bus.m0_write;
      mon_req1 = bus.m1_read | bus.m1_write;
      mon_acc0 = mon_req0 & !bus.m0_waitrequest;
      mon_acc1 = mon_req1 & !bus.m1_waitrequest;
      check_eq("wait0_noreq", bus.m0_waitrequest & !mon_req0, 0);
      check_eq("wait1_noreq", bus.m1_waitrequest & !mon_req1, 0);
      check_eq("one_accept", mon_acc0 & mon_acc1, 0);
      check_eq("no_bubble", mon_acc0 | mon_acc1, mon_req0 | mon_req1);
      check_eq("mem_cs", bus.mem_chipselect, mon_acc0 | mon_acc1);
      check_eq("mem_clken", bus.mem_clken, 1);
      if (mon_acc0 | mon_acc1) begin
        mon_g    = mon_acc1;
        mon_wr   = mon_g ? bus.m1_write : bus.m0_write;
        mon_addr = mon_g ? bus.m1_address : bus.m0_address;
        mon_be   = mon_g ? bus.m1_byteenable : bus.m0_byteenable;
        mon_wd   = mon_g ? bus.m1_writedata : bus.m0_writedata;
        check_eq("mem_write", bus.mem_write, mon_wr);
        check_eq("mem_addr", bus.mem_address, mon_addr);
        check_eq("mem_be", bus.mem_byteenable, mon_wr ? mon_be : 4'hF);
        if (mon_wr) begin
          check_eq("mem_wdata", bus.mem_writedata, mon_wd);
          for (int b = 0; b < 4; b++)
            if (mon_be[b]) ref_mem[mon_addr][8*b +: 8] = mon_wd[8*b +: 8];
        end else begin
          sb_q.push_back('{sel: mon_g, data: ref_mem[mon_addr]});
        end
      end else begin
        check_eq("mem_write_idle", bus.mem_write, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic rd, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
      bus.m0_writedata = d; bus.m0_byteenable = be;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
      bus.m1_writedata = d; bus.m1_byteenable = be;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    set_m(0, 1, 0, 12'h001, '0, 4'h0);
    set_m(1, 0, 0, 12'h000, '0, 4'h0);
    reset = 1'b1;

    // Reset held three cycles with m0 requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_wait0", bus.m0_waitrequest, 1);
      check_eq("rst_cs_stim", bus.mem_chipselect, 0);
      cyc();
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("first_acc", bus.m0_waitrequest, 0);
    cyc();
    set_m(0, 0, 0, 12'h000, '0, 4'h0);

    // Partial write then read-back
    set_m(0, 0, 1, 12'h010, 32'hDEADBEEF, 4'b0011);
    @(negedge clk);
    check_eq("wr_acc", bus.m0_waitrequest, 0);
    cyc();
    set_m(0, 1, 0, 12'h010, '0, 4'h0);
    @(negedge clk);
    check_eq("rd_acc", bus.m0_waitrequest, 0);
    cyc();
    set_m(0, 0, 0, 12'h000, '0, 4'h0);
    @(negedge clk);
    check_eq("rdv_lat", bus.m0_readdatavalid, 1);
    check_eq("rd_low16", {16'h0, bus.m0_readdata[15:0]}, 32'h0000BEEF);
    cyc();
    set_m(1, 0, 1, 12'h011, 32'hCAFEF00D, 4'hF);
    cyc();
    set_m(1, 0, 0, 12'h000, '0, 4'h0);
    cyc();

    // Reset one cycle after a read accept drops the return
    set_m(0, 1, 0, 12'h010, '0, 4'h0);
    @(negedge clk);
    check_eq("mid_acc", bus.m0_waitrequest, 0);
    cyc();
    reset = 1'b1;
    set_m(0, 0, 0, 12'h000, '0, 4'h0);
    @(negedge clk);
    check_eq("mid_rdv", bus.m0_readdatavalid, 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_state", 32'(dut.u_arb.state_q), 32'(IDLE));
    check_eq("mid_rdv_after", bus.m0_readdatavalid, 0);
    cyc();

    // Both masters reading continuously: 4/4/4 rotation
    set_m(0, 1, 0, 12'h010, '0, 4'h0);
    set_m(1, 1, 0, 12'h011, '0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("rr_grant0", !bus.m0_waitrequest, ((i / 4) % 2) == 0);
      check_eq("rr_grant1", !bus.m1_waitrequest, ((i / 4) % 2) == 1);
      cyc();
    end
    set_m(0, 0, 0, 12'h000, '0, 4'h0);
    set_m(1, 0, 0, 12'h000, '0, 4'h0);
    cyc();

    // m1 alone: ten back-to-back reads, hold count saturates
    for (int i = 0; i < 10; i++) begin
      set_m(1, 1, 0, 12'h100 + 12'(i), '0, 4'h0);
      @(negedge clk);
      check_eq("solo_wait1", bus.m1_waitrequest, 0);
      check_eq("hold_le_max", dut.u_arb.hold_cnt_q <= 4'd4, 1);
      cyc();
    end
    check_eq("solo_hold", dut.u_arb.hold_cnt_q, 4);
    check_eq("solo_state", 32'(dut.u_arb.state_q), 32'(OWN1));
    set_m(1, 0, 0, 12'h000, '0, 4'h0);
    cyc();

    // Read and write together: treated as a write
    set_m(0, 1, 1, 12'h020, 32'h12345678, 4'hF);
    @(negedge clk);
    check_eq("rw_acc", bus.m0_waitrequest, 0);
    check_eq("rw_memwr", bus.mem_write, 1);
    cyc();
    set_m(0, 0, 0, 12'h000, '0, 4'h0);
    @(negedge clk);
    check_eq("rw_no_rdv", bus.m0_readdatavalid, 0);
    check_eq("rw_ram", ram[12'h020], 32'h12345678);
    cyc();
    set_m(0, 1, 0, 12'h020, '0, 4'h0);
    cyc();
    set_m(0, 0, 0, 12'h000, '0, 4'h0);
    repeat (3) cyc();

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
